// File: rtl/d_issue_ctrl_pkg.sv
// Shared types and constants for the decode-stage issue controller.
package d_issue_ctrl_pkg;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  localparam int unsigned RegIdxW = 5;
  localparam logic [RegIdxW-1:0] RegX0 = '0;

endpackage

// File: rtl/d_scoreboard.sv
// Register scoreboard: one busy bit per architectural register, writeback bypass on the
// three lookup ports, set-wins-over-clear update and a popcount of the stored bits.
module d_scoreboard
  import d_issue_ctrl_pkg::*;
#(
  parameter int unsigned NREGS     = 32,
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned IdxW      = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [IdxW-1:0] rd_a_i,
  input  logic [IdxW-1:0] rd_b_i,
  input  logic [IdxW-1:0] rd_d_i,
  output logic            busy_a_o,
  output logic            busy_b_o,
  output logic            busy_d_o,
  input  logic            set_en_i,
  input  logic [IdxW-1:0] set_reg_i,
  input  logic            clr_en_i,
  input  logic [IdxW-1:0] clr_reg_i,
  output logic [IdxW:0]   busy_count_o
);

  logic [NREGS-1:0] sb_q, sb_d;
  logic [IdxW:0]    count;

  function automatic logic is_busy(input logic [IdxW-1:0] r);
    logic clr;
    clr = (WB_BYPASS != 0) && clr_en_i && (clr_reg_i == r);
    return sb_q[r] && !clr;
  endfunction

  always_comb begin
    busy_a_o = is_busy(rd_a_i);
    busy_b_o = is_busy(rd_b_i);
    busy_d_o = is_busy(rd_d_i);
  end

  // Clear first so a same-cycle set on the same register wins.
  always_comb begin
    sb_d = sb_q;
    if (clr_en_i) sb_d[clr_reg_i] = 1'b0;
    if (set_en_i && (set_reg_i != IdxW'(RegX0))) sb_d[set_reg_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      count = count + {{IdxW{1'b0}}, sb_q[i]};
    end
  end

  assign busy_count_o = count;

endmodule

// File: rtl/d_issue_ctrl.sv
// Decode issue controller: hazard detection against the scoreboard, RUN/FLUSH sequencing
// after redirects, and a saturating stall-cycle counter.
module d_issue_ctrl
  import d_issue_ctrl_pkg::*;
#(
  parameter int unsigned NREGS        = 2 ** RegIdxW,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned WB_BYPASS    = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       d_valid,
  input  logic [$clog2(NREGS)-1:0]   regA,
  input  logic [$clog2(NREGS)-1:0]   regB,
  input  logic                       use_A,
  input  logic                       use_B,
  input  logic [$clog2(NREGS)-1:0]   regD,
  input  logic                       w_en,
  input  logic                       x_ready,
  input  logic                       wb_valid,
  input  logic [$clog2(NREGS)-1:0]   wb_reg,
  input  logic                       redirect,
  output logic                       issue,
  output logic                       d_ready,
  output logic                       stall,
  output logic                       flush,
  output logic [$clog2(NREGS):0]     busy_count,
  output logic [CNT_W-1:0]           stall_cycles
);

  localparam int unsigned IdxW = $clog2(NREGS);
  localparam int unsigned FlW  = $clog2(FLUSH_CYCLES + 1);

  state_e           state_q, state_d;
  logic [FlW-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  logic          busy_a, busy_b, busy_d;
  logic          run, hazard, issue_raw, stall_raw, ready_raw, flush_raw;
  logic [IdxW:0] sb_count;

  d_scoreboard #(
    .NREGS     (NREGS),
    .WB_BYPASS (WB_BYPASS),
    .IdxW      (IdxW)
  ) u_scoreboard (
    .clk_i        (clock),
    .rst_ni       (reset),
    .rd_a_i       (regA),
    .rd_b_i       (regB),
    .rd_d_i       (regD),
    .busy_a_o     (busy_a),
    .busy_b_o     (busy_b),
    .busy_d_o     (busy_d),
    .set_en_i     (issue_raw && w_en),
    .set_reg_i    (regD),
    .clr_en_i     (wb_valid),
    .clr_reg_i    (wb_reg),
    .busy_count_o (sb_count)
  );

  always_comb begin
    run       = (state_q == StRun) && !redirect;
    hazard    = (use_A && busy_a) || (use_B && busy_b) ||
                (w_en && (regD != IdxW'(RegX0)) && busy_d);
    issue_raw = run && d_valid && x_ready && !hazard;
    stall_raw = run && d_valid && !issue_raw;
    ready_raw = run && (!d_valid || issue_raw);
    flush_raw = redirect || (state_q == StFlush);
  end

  // Every output reads as zero while reset is held low.
  always_comb begin
    issue        = reset && issue_raw;
    d_ready      = reset && ready_raw;
    stall        = reset && stall_raw;
    flush        = reset && flush_raw;
    busy_count   = reset ? sb_count : '0;
    stall_cycles = reset ? scnt_q : '0;
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (redirect) begin
      state_d = StFlush;
      fcnt_d  = FlW'(FLUSH_CYCLES);
    end else if (state_q == StFlush) begin
      if (fcnt_q <= FlW'(1)) begin
        state_d = StRun;
        fcnt_d  = '0;
      end else begin
        fcnt_d = fcnt_q - FlW'(1);
      end
    end
  end

  always_comb begin
    scnt_d = scnt_q;
    if (stall_raw && (scnt_q != '1)) scnt_d = scnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StRun;
      fcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      scnt_q  <= scnt_d;
    end
  end

endmodule
